// File: rtl/input_byte_capture_if.sv
// rtl/input_byte_capture_if.sv - switch/button inputs, read request and FIFO status bundle
interface input_byte_capture_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]         data_in;
    logic               button;
    logic               read_req;
    logic [7:0]         data_out;
    logic               data_valid;
    logic               full;
    logic [LEVEL_W-1:0] level;
    logic               overflow;

    // Environment side: drives switches, button and read requests.
    modport master (
        output data_in, button, read_req,
        input  data_out, data_valid, full, level, overflow
    );

    // Capture block side.
    modport slave (
        input  data_in, button, read_req,
        output data_out, data_valid, full, level, overflow
    );
endinterface

// File: rtl/input_byte_capture.sv
// rtl/input_byte_capture.sv - debounced button captures switch byte into a small FIFO
module input_byte_capture #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input_byte_capture_if.slave  bus
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LEVEL_W = PTR_W + 1;

    localparam logic [15:0]        DB_LAST    = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(FIFO_DEPTH);

    // Debouncer state
    logic        btn_db;
    logic [15:0] db_cnt;
    logic        btn_db_next;
    logic [15:0] db_cnt_next;
    logic        press;

    // FIFO state
    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [LEVEL_W-1:0] count;
    logic               ovf;

    logic               empty;
    logic               is_full;
    logic               do_pop;
    logic               do_push;
    logic               drop;
    logic [LEVEL_W-1:0] count_next;

    // Debounce: count consecutive cycles the raw button disagrees with the
    // accepted level; accept the new level once the run reaches DEBOUNCE_CYCLES.
    always_comb begin
        btn_db_next = btn_db;
        db_cnt_next = 16'd0;
        press       = 1'b0;
        if (bus.button != btn_db) begin
            if (db_cnt == DB_LAST) begin
                btn_db_next = ~btn_db;
                db_cnt_next = 16'd0;
                press       = ~btn_db;
            end else begin
                db_cnt_next = db_cnt + 16'd1;
            end
        end
    end

    // Debounce state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_db <= 1'b0;
            db_cnt <= 16'd0;
        end else begin
            btn_db <= btn_db_next;
            db_cnt <= db_cnt_next;
        end
    end

    // FIFO control: a pop frees the slot a same-edge push may use when full;
    // a press against a full FIFO with no pop is dropped and flagged.
    always_comb begin
        empty      = (count == '0);
        is_full    = (count == LEVEL_FULL);
        do_pop     = bus.read_req && !empty;
        do_push    = press && (!is_full || do_pop);
        drop       = press && is_full && !do_pop;
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + LEVEL_W'(1);
        end else if (do_pop && !do_push) begin
            count_next = count - LEVEL_W'(1);
        end
    end

    // Pointer, level and sticky overflow registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            count <= count_next;
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

    // Byte storage; contents are hidden behind the level so need no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    // Head byte and status presented combinationally from registered state
    always_comb begin
        bus.data_out   = empty ? 8'h00 : mem[rd_ptr];
        bus.data_valid = !empty;
        bus.full       = is_full;
        bus.level      = count;
        bus.overflow   = ovf;
    end
endmodule
